board_writer: RTL

- Writable Connect-Four board store: the write side of the 6x7 tile matrix that the display and game logic read.
- Accepts a "drop token in column" request through a valid/ready handshake.
- Scans the column bottom-up for the lowest empty cell, writes the player code there, and reports the landing row or an error.
- Provides a combinational (x, y) read port returning the 2-bit cell code, so it directly replaces the fixed board pattern used by the renderer.

---
 rtl/connect4_pkg.sv | 35 +++
 rtl/board_read_mux.sv | 26 ++
 rtl/board_writer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-Four definitions: board geometry, cell codes, move status and
// writer FSM states. Imported by the board writer, renderer and win checker.
package connect4_pkg;

    localparam int unsigned ROWS = 6;
    localparam int unsigned COLS = 7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        P1    = 2'd1,
        P2    = 2'd2
    } cell_t;

    typedef enum logic [1:0] {
        OK         = 2'd0,
        COL_FULL   = 2'd1,
        BAD_COL    = 2'd2,
        BAD_PLAYER = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_WRITE,
        S_DONE
    } state_t;

    // Bit offset of cell (row, col) in a row-major packed board, 2 bits per cell.
    function automatic int unsigned cell_base(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned ncols);
        return 2 * (row * ncols + col);
    endfunction

endpackage

// File: rtl/board_read_mux.sv
// Combinational (x, y) read port into the packed board; out-of-range
// coordinates read as an empty cell.
module board_read_mux #(
    parameter int unsigned ROWS = connect4_pkg::ROWS,
    parameter int unsigned COLS = connect4_pkg::COLS
) (
    input  logic [2*ROWS*COLS-1:0] cells,
    input  logic [2:0]             rd_x,
    input  logic [2:0]             rd_y,
    output logic [1:0]             rd_value
);
    import connect4_pkg::*;

    localparam int unsigned IW = $clog2(2 * ROWS * COLS);

    logic [IW-1:0] rd_base;

    always_comb begin
        rd_base  = IW'(cell_base(32'(rd_y), 32'(rd_x), COLS));
        rd_value = EMPTY;
        if (32'(rd_x) < COLS && 32'(rd_y) < ROWS) begin
            rd_value = cells[rd_base +: 2];
        end
    end

endmodule

// File: rtl/board_writer.sv
// Write side of the Connect-Four board: accepts "drop token in column" moves,
// scans the column bottom-up for the landing cell and reports the result.
module board_writer #(
    parameter int unsigned ROWS = connect4_pkg::ROWS,
    parameter int unsigned COLS = connect4_pkg::COLS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       move_valid,
    input  logic [2:0] move_col,
    input  logic [1:0] move_player,
    output logic       move_ready,
    output logic       done,
    output logic [1:0] done_status,
    output logic [2:0] done_row,
    output logic       full,
    output logic [5:0] move_count,
    input  logic [2:0] rd_x,
    input  logic [2:0] rd_y,
    output logic [1:0] rd_value
);
    import connect4_pkg::*;

    localparam int unsigned IW          = $clog2(2 * ROWS * COLS);
    localparam logic [5:0]  TOTAL_CELLS = 6'(ROWS * COLS);
    localparam logic [2:0]  BOTTOM_ROW  = 3'(ROWS - 1);

    state_t                  state;
    logic [2*ROWS*COLS-1:0]  cells;
    logic [2:0]              col_q;
    logic [2:0]              row_ptr;
    logic [1:0]              player_q;
    logic [IW-1:0]           scan_base;
    logic [1:0]              scan_cell;

    always_comb begin
        scan_base = IW'(cell_base(32'(row_ptr), 32'(col_q), COLS));
        scan_cell = cells[scan_base +: 2];
    end

    assign full = (move_count == TOTAL_CELLS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cells       <= '0;
            move_count  <= '0;
            move_ready  <= 1'b1;
            done        <= 1'b0;
            done_status <= OK;
            done_row    <= '0;
            col_q       <= '0;
            row_ptr     <= '0;
            player_q    <= EMPTY;
        end else if (clear) begin
            // Wipe aborts any move in flight: no write and no done pulse.
            state      <= S_IDLE;
            cells      <= '0;
            move_count <= '0;
            move_ready <= 1'b1;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (move_valid) begin
                        col_q      <= move_col;
                        player_q   <= move_player;
                        move_ready <= 1'b0;
                        if (32'(move_col) >= COLS) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            done_status <= BAD_COL;
                            done_row    <= '0;
                        end else if (move_player != P1 && move_player != P2) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            done_status <= BAD_PLAYER;
                            done_row    <= '0;
                        end else begin
                            row_ptr <= BOTTOM_ROW;
                            state   <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (scan_cell == EMPTY) begin
                        state <= S_WRITE;
                    end else if (row_ptr == '0) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        done_status <= COL_FULL;
                        done_row    <= '0;
                    end else begin
                        row_ptr <= row_ptr - 3'd1;
                    end
                end
                S_WRITE: begin
                    cells[scan_base +: 2] <= player_q;
                    if (move_count != TOTAL_CELLS) begin
                        move_count <= move_count + 6'd1;
                    end
                    state       <= S_DONE;
                    done        <= 1'b1;
                    done_status <= OK;
                    done_row    <= row_ptr;
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    move_ready <= 1'b1;
                end
                default: begin
                    state      <= S_IDLE;
                    move_ready <= 1'b1;
                end
            endcase
        end
    end

    board_read_mux #(
        .ROWS(ROWS),
        .COLS(COLS)
    ) u_read_mux (
        .cells   (cells),
        .rd_x    (rd_x),
        .rd_y    (rd_y),
        .rd_value(rd_value)
    );

endmodule
